// File: rtl/eq_band_mixer_if.sv
// FIR-bank-to-mixer bundle: per-band stereo accumulations in, mixed 24-bit stereo sample out.
interface eq_band_mixer_if #(
    parameter int unsigned NUM_BANDS = 4
);
    localparam int unsigned BAND_W = 48;
    localparam int unsigned OUT_W  = 24;

    logic                          fir_valid;
    logic [BAND_W*NUM_BANDS-1:0]   l_band_in;
    logic [BAND_W*NUM_BANDS-1:0]   r_band_in;
    logic signed [OUT_W-1:0]       l_out;
    logic signed [OUT_W-1:0]       r_out;
    logic                          out_valid;
    logic                          busy;
    logic                          overrun;

    modport master (
        output fir_valid, l_band_in, r_band_in,
        input  l_out, r_out, out_valid, busy, overrun
    );

    modport slave (
        input  fir_valid, l_band_in, r_band_in,
        output l_out, r_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/eq_band_mixer.sv
// Per-band gain, sum, round and 24-bit saturation of the equalizer FIR bank outputs.
// One band is multiplied per cycle; a frame takes NUM_BANDS+2 cycles from trigger to strobe.
module eq_band_mixer #(
    parameter int unsigned NUM_BANDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        audio_en,
    input  logic        gain_wr_en,
    input  logic [3:0]  gain_sel,
    input  logic [15:0] gain_wr_data,
    eq_band_mixer_if.slave bus
);
    localparam int unsigned BAND_W = 48;
    localparam int unsigned GAIN_W = 16;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned ACC_W  = 72;
    localparam int unsigned OUT_W  = 24;
    localparam int unsigned SHIFT  = 29;
    localparam int unsigned KW     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    localparam logic [KW-1:0]              K_LAST   = KW'(NUM_BANDS - 1);
    localparam logic signed [GAIN_W-1:0]   GAIN_ONE = 16'sh4000;
    localparam logic signed [ACC_W-1:0]    RND_BIAS = 72'sh10000000;
    localparam logic signed [ACC_W-1:0]    SAT_MAX  = 72'sd8388607;
    localparam logic signed [ACC_W-1:0]    SAT_MIN  = -72'sd8388608;

    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

    state_t                   state, state_nxt;
    logic                     fir_valid_d;
    logic                     trig_c;
    logic                     load_c, acc_en_c, out_en_c;
    logic [KW-1:0]            k;
    logic signed [GAIN_W-1:0] g    [NUM_BANDS];
    logic signed [GAIN_W-1:0] sh_g [NUM_BANDS];
    logic signed [BAND_W-1:0] sh_l [NUM_BANDS];
    logic signed [BAND_W-1:0] sh_r [NUM_BANDS];
    logic signed [ACC_W-1:0]  acc_l, acc_r;
    logic signed [PROD_W-1:0] prod_l_c, prod_r_c;
    logic signed [ACC_W-1:0]  rnd_l_c, rnd_r_c;

    function automatic logic signed [OUT_W-1:0] sat24(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 24'sh7FFFFF;
        else if (v < SAT_MIN) return 24'sh800000;
        else                  return OUT_W'(v);
    endfunction

    // fir_valid_d idles high so a level that is already high never looks like a new frame
    always_ff @(posedge clk) begin
        if (!reset_n || !audio_en) fir_valid_d <= 1'b1;
        else                       fir_valid_d <= bus.fir_valid;
    end

    assign trig_c = bus.fir_valid & ~fir_valid_d;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        acc_en_c  = 1'b0;
        out_en_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig_c) begin
                    load_c    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_en_c = 1'b1;
                if (k == K_LAST) state_nxt = ROUND;
            end
            ROUND: begin
                out_en_c  = 1'b1;
                state_nxt = OUT;
            end
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!audio_en) begin
            state_nxt = IDLE;
            load_c    = 1'b0;
            acc_en_c  = 1'b0;
            out_en_c  = 1'b0;
        end
    end

    // Live gain table survives an audio_en abort; only reset restores unity
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BANDS); i++) g[i] <= GAIN_ONE;
        end else if (gain_wr_en && (32'(gain_sel) < NUM_BANDS)) begin
            g[gain_sel[KW-1:0]] <= $signed(gain_wr_data);
        end
    end

    // Shadow copies decouple the frame from band/gain changes after capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BANDS); i++) begin
                sh_l[i] <= '0;
                sh_r[i] <= '0;
                sh_g[i] <= GAIN_ONE;
            end
        end else if (load_c) begin
            for (int i = 0; i < int'(NUM_BANDS); i++) begin
                sh_l[i] <= $signed(bus.l_band_in[BAND_W*i +: BAND_W]);
                sh_r[i] <= $signed(bus.r_band_in[BAND_W*i +: BAND_W]);
                sh_g[i] <= g[i];
            end
        end
    end

    always_comb begin
        prod_l_c = PROD_W'(sh_l[k]) * PROD_W'(sh_g[k]);
        prod_r_c = PROD_W'(sh_r[k]) * PROD_W'(sh_g[k]);
        rnd_l_c  = (acc_l + RND_BIAS) >>> SHIFT;
        rnd_r_c  = (acc_r + RND_BIAS) >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !audio_en) begin
            acc_l <= '0;
            acc_r <= '0;
            k     <= '0;
        end else if (load_c) begin
            acc_l <= '0;
            acc_r <= '0;
            k     <= '0;
        end else if (acc_en_c) begin
            acc_l <= acc_l + ACC_W'(prod_l_c);
            acc_r <= acc_r + ACC_W'(prod_r_c);
            k     <= (k == K_LAST) ? '0 : k + KW'(1);
        end
    end

    // Result is registered at the end of ROUND so it is visible during OUT with the strobe
    always_ff @(posedge clk) begin
        if (!reset_n || !audio_en) begin
            bus.l_out     <= '0;
            bus.r_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.out_valid <= out_en_c;
            bus.busy      <= (state_nxt != IDLE);
            if (out_en_c) begin
                bus.l_out <= sat24(rnd_l_c);
                bus.r_out <= sat24(rnd_r_c);
            end
            if (trig_c && (state != IDLE)) bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer: table of gain/band vectors plus overrun, abort and reset sequences.
module tb_eq_band_mixer;
    localparam int unsigned NB = 4;
    localparam int unsigned BW = 48 * NB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        audio_en;
    logic        gain_wr_en;
    logic [3:0]  gain_sel;
    logic [15:0] gain_wr_data;
    int          total = 0;
    int          bad   = 0;

    eq_band_mixer_if #(.NUM_BANDS(NB)) mix_if ();

    eq_band_mixer #(.NUM_BANDS(NB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_en     (audio_en),
        .gain_wr_en   (gain_wr_en),
        .gain_sel     (gain_sel),
        .gain_wr_data (gain_wr_data),
        .bus          (mix_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]        g;
        logic [BW-1:0]      lb;
        logic [BW-1:0]      rb;
        logic signed [23:0] el;
        logic signed [23:0] er;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [BW-1:0] raw4(input longint b0, input longint b1,
                                           input longint b2, input longint b3);
        return {48'(b3), 48'(b2), 48'(b1), 48'(b0)};
    endfunction

    // Sample-scale band values carry the 2^15 coefficient factor
    function automatic logic [BW-1:0] smp4(input longint b0, input longint b1,
                                           input longint b2, input longint b3);
        return raw4(b0 * 32768, b1 * 32768, b2 * 32768, b3 * 32768);
    endfunction

    function automatic logic [63:0] g4(input logic [15:0] g0, input logic [15:0] g1,
                                       input logic [15:0] g2, input logic [15:0] g3);
        return {g3, g2, g1, g0};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_gain(input logic [3:0] sel, input logic [15:0] val);
        gain_wr_en = 1'b1; gain_sel = sel; gain_wr_data = val;
        @(posedge clk); #1;
        gain_wr_en = 1'b0;
    endtask

    // Returns one cycle after capture (T+1), with band inputs already scrambled
    task automatic start_frame(input logic [BW-1:0] lb, input logic [BW-1:0] rb,
                               input logic wr_at_trig, input logic [15:0] wr_val);
        mix_if.fir_valid = 1'b0;
        @(posedge clk); #1;
        mix_if.fir_valid = 1'b1;
        mix_if.l_band_in = lb;
        mix_if.r_band_in = rb;
        if (wr_at_trig) begin
            gain_wr_en = 1'b1; gain_sel = 4'd0; gain_wr_data = wr_val;
        end
        @(posedge clk); #1;
        gain_wr_en = 1'b0;
        mix_if.l_band_in = {NB{48'h5a5a_1234_9876}};
        mix_if.r_band_in = ~rb;
    endtask

    task automatic count_pulses(input int cycles, output int n, output longint last_l);
        n = 0; last_l = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (mix_if.out_valid) begin
                n++;
                last_l = mix_if.l_out;
            end
        end
    endtask

    task automatic run_frame(input string name, input logic [BW-1:0] lb, input logic [BW-1:0] rb,
                             input logic signed [23:0] el, input logic signed [23:0] er,
                             input logic wr_at_trig, input logic [15:0] wr_val);
        int lat = -1;
        start_frame(lb, rb, wr_at_trig, wr_val);
        check({name, " busy_start"}, mix_if.busy, 1);
        if (mix_if.out_valid) lat = 1;
        for (int n = 2; n <= 20 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (mix_if.out_valid) lat = n;
        end
        check({name, " latency"}, lat, 6);
        if (lat > 0) begin
            check({name, " l_out"}, mix_if.l_out, el);
            check({name, " r_out"}, mix_if.r_out, er);
            check({name, " busy_out"}, mix_if.busy, 1);
            @(posedge clk); #1;
            check({name, " pulse_end"}, mix_if.out_valid, 0);
            check({name, " busy_end"}, mix_if.busy, 0);
            check({name, " l_hold"}, mix_if.l_out, el);
        end
    endtask

    initial begin
        int     n;
        longint last_l;

        vecs[0] = '{g4(16'h4000, 0, 0, 0), smp4(1000, 0, 0, 0), smp4(-500, 0, 0, 0), 1000, -500};
        vecs[1] = '{g4(16'h8000, 0, 0, 0), smp4(1000, 0, 0, 0), smp4(300, 0, 0, 0), -2000, -600};
        vecs[2] = '{g4(16'h4000, 16'h4000, 16'h4000, 16'h4000),
                    raw4(64'sd274877906944, 64'sd274877906944, 64'sd274877906944, 64'sd274877906944),
                    raw4(-64'sd274877906944, -64'sd274877906944, -64'sd274877906944, -64'sd274877906944),
                    8388607, -8388608};
        vecs[3] = '{g4(16'h4000, 0, 0, 0), raw4(16384, 0, 0, 0), raw4(-16384, 0, 0, 0), 1, 0};
        vecs[4] = '{g4(16'h4000, 0, 0, 0), raw4(16383, 0, 0, 0), raw4(-16385, 0, 0, 0), 0, -1};
        vecs[5] = '{g4(16'h4000, 16'h4000, 16'hC000, 16'h2000),
                    smp4(100, 200, 50, 400), smp4(-10, 20, 30, -40), 450, -40};
        vecs[6] = '{g4(16'h4000, 16'h4000, 0, 0), smp4(8388607, 1, 0, 0),
                    smp4(-8388608, 0, 0, 0), 8388607, -8388608};
        vecs[7] = '{g4(16'h4000, 16'h4000, 0, 0), smp4(8388607, 0, 0, 0),
                    smp4(-8388608, -1, 0, 0), 8388607, -8388608};

        reset_n = 1'b0; audio_en = 1'b1; gain_wr_en = 1'b0; gain_sel = '0; gain_wr_data = '0;
        mix_if.fir_valid = 1'b1; mix_if.l_band_in = '0; mix_if.r_band_in = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check("rst l_out", mix_if.l_out, 0);
        check("rst r_out", mix_if.r_out, 0);
        check("rst out_valid", mix_if.out_valid, 0);
        check("rst busy", mix_if.busy, 0);
        check("rst overrun", mix_if.overrun, 0);
        count_pulses(4, n, last_l);
        check("idle_high_no_trigger", n, 0);

        run_frame("default_gains", smp4(1, 2, 3, 4), smp4(-1, -2, -3, -4), 10, -10, 1'b0, 16'h0);

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < int'(NB); b++) write_gain(4'(b), vecs[i].g[16*b +: 16]);
            write_gain(4'd7, 16'h0000);
            run_frame($sformatf("vec%0d", i), vecs[i].lb, vecs[i].rb, vecs[i].el, vecs[i].er,
                      1'b0, 16'h0);
        end

        // Gain written in the trigger cycle must not reach the captured frame
        write_gain(4'd0, 16'h4000); write_gain(4'd1, 0); write_gain(4'd2, 0); write_gain(4'd3, 0);
        run_frame("wr_at_trig", smp4(1000, 0, 0, 0), smp4(0, 0, 0, 0), 1000, 0, 1'b1, 16'h8000);
        run_frame("wr_after", smp4(1000, 0, 0, 0), smp4(0, 0, 0, 0), -2000, 0, 1'b0, 16'h0);

        // Second rise three cycles into the first frame is dropped
        write_gain(4'd0, 16'h4000);
        start_frame(smp4(1000, 0, 0, 0), smp4(-7, 0, 0, 0), 1'b0, 16'h0);
        mix_if.fir_valid = 1'b0;
        @(posedge clk); #1;
        check("ovr not_yet", mix_if.overrun, 0);
        @(posedge clk); #1;
        mix_if.fir_valid = 1'b1;
        mix_if.l_band_in = smp4(77, 77, 77, 77);
        count_pulses(15, n, last_l);
        check("ovr pulses", n, 1);
        check("ovr l_out", last_l, 1000);
        check("ovr sticky", mix_if.overrun, 1);
        audio_en = 1'b0;
        @(posedge clk); #1;
        check("ovr cleared", mix_if.overrun, 0);
        check("dis l_out", mix_if.l_out, 0);
        audio_en = 1'b1;

        // audio_en abort during ACCUM
        write_gain(4'd0, 16'h8000);
        run_frame("pre_abort", smp4(300, 0, 0, 0), smp4(0, 0, 0, 0), -600, 0, 1'b0, 16'h0);
        start_frame(smp4(1000, 0, 0, 0), smp4(1000, 0, 0, 0), 1'b0, 16'h0);
        @(posedge clk); #1;
        audio_en = 1'b0;
        @(posedge clk); #1;
        check("abort busy", mix_if.busy, 0);
        check("abort l_out", mix_if.l_out, 0);
        check("abort r_out", mix_if.r_out, 0);
        audio_en = 1'b1;
        count_pulses(12, n, last_l);
        check("abort no_pulse", n, 0);
        run_frame("gain_kept", smp4(1000, 0, 0, 0), smp4(-1000, 0, 0, 0), -2000, 2000, 1'b0, 16'h0);

        // reset_n abort during ACCUM
        start_frame(smp4(1000, 0, 0, 0), smp4(0, 0, 0, 0), 1'b0, 16'h0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rabort busy", mix_if.busy, 0);
        check("rabort l_out", mix_if.l_out, 0);
        check("rabort r_out", mix_if.r_out, 0);
        reset_n = 1'b1;
        count_pulses(12, n, last_l);
        check("rabort no_pulse", n, 0);
        run_frame("gain_reset", smp4(1, 2, 3, 4), smp4(-1, -2, -3, -4), 10, -10, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
